// File: rtl/hazard_pkg.sv
// Shared definitions for the load-use hazard unit.
//   REG_AW_DEF   default register address width
//   sb_entry_t   layout of one pending-load slot (valid, rd, cnt) in the default configuration
//   reg_is_zero  true when a register address is x0 (address zero-extended to 32 bits)
package hazard_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 1;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
    logic [CNT_W_DEF-1:0]  cnt;
  } sb_entry_t;

  function automatic logic reg_is_zero(input logic [31:0] regAddr);
    return (regAddr == 32'd0);
  endfunction

endpackage

// File: rtl/load_use_scoreboard_sb_slot.sv
// One pending-load slot: holds valid/rd/cnt, counts down toward forwardability
// and compares its destination against both ID source operands.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   freeze_i            hold the countdown
//   alloc_i, allocRd_i  claim this slot for a load to allocRd_i (slot must be invalid)
//   rs1_i, rs2_i        ID source addresses to compare
//   valid_o             slot holds a pending load
//   hit1_o, hit2_o      slot is valid and rd equals rs1_i / rs2_i
module sb_slot
  import hazard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              freeze_i,
  input  logic              alloc_i,
  input  logic [REG_AW-1:0] allocRd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  output logic              valid_o,
  output logic              hit1_o,
  output logic              hit2_o
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  logic              validReg;
  logic [REG_AW-1:0] rdReg;
  logic [CNT_W-1:0]  cntReg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      validReg <= 1'b0;
      rdReg    <= '0;
      cntReg   <= '0;
    end else if (!freeze_i) begin
      if (alloc_i) begin
        validReg <= 1'b1;
        rdReg    <= allocRd_i;
        cntReg   <= CNT_W'(LOAD_LAT);
      end else if (validReg) begin
        cntReg <= cntReg - 1'b1;
        // Reaching zero on this edge means the data is forwardable next cycle.
        if (cntReg == CNT_W'(1)) begin
          validReg <= 1'b0;
        end
      end
    end
  end

  assign valid_o = validReg;
  assign hit1_o  = validReg && (rdReg == rs1_i);
  assign hit2_o  = validReg && (rdReg == rs2_i);

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use hazard unit for the ID stage. Tracks in-flight loads in NUM_ENTRIES
// slots and stalls IF/ID (with a bubble into ID/EX) while an ID source operand
// matches a pending load, or while a load sits in ID and the table is full.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   MemRead_i, RD_i              ID instruction is a load, and its destination
//   RS1_i/RS2_i, RS1Used_i/RS2Used_i  ID sources and whether they are read
//   flush_i                      ID instruction squashed, never allocates
//   freeze_i                     pipeline freeze: countdown and perf counter hold
//   noOpSignal_o, stallSignal_o  bubble / hold IF/ID (combinational hazard)
//   PCWriteSignal_o              PC update enable (inverse of the hazard)
//   full_o                       every slot valid
//   stallCount_o                 saturating count of stalled, unfrozen cycles
module load_use_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int NUM_ENTRIES = 4,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_EXEMPT = 1,
  parameter int PERF_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic [REG_AW-1:0] RD_i,
  input  logic [REG_AW-1:0] RS1_i,
  input  logic [REG_AW-1:0] RS2_i,
  input  logic              RS1Used_i,
  input  logic              RS2Used_i,
  input  logic              flush_i,
  input  logic              freeze_i,
  output logic              noOpSignal_o,
  output logic              stallSignal_o,
  output logic              PCWriteSignal_o,
  output logic              full_o,
  output logic [PERF_W-1:0] stallCount_o
);

  logic [NUM_ENTRIES-1:0] slotValid;
  logic [NUM_ENTRIES-1:0] hit1;
  logic [NUM_ENTRIES-1:0] hit2;
  logic [NUM_ENTRIES-1:0] grant;
  logic                   rs1Zero;
  logic                   rs2Zero;
  logic                   rdZero;
  logic                   match1;
  logic                   match2;
  logic                   hz;
  logic                   allocEn;
  logic [PERF_W-1:0]      stallCountReg;

  // x0 is hard-wired, so it never needs tracking when exemption is on.
  assign rs1Zero = (ZERO_EXEMPT != 0) && reg_is_zero(32'(RS1_i));
  assign rs2Zero = (ZERO_EXEMPT != 0) && reg_is_zero(32'(RS2_i));
  assign rdZero  = (ZERO_EXEMPT != 0) && reg_is_zero(32'(RD_i));

  assign full_o = &slotValid;
  assign match1 = RS1Used_i && !rs1Zero && (|hit1);
  assign match2 = RS2Used_i && !rs2Zero && (|hit2);
  assign hz     = match1 | match2 | (full_o & MemRead_i);

  assign noOpSignal_o    = hz;
  assign stallSignal_o   = hz;
  assign PCWriteSignal_o = !hz;

  // A load that is stalled stays in ID and allocates later; only a load
  // actually leaving ID claims a slot.
  assign allocEn = MemRead_i && !hz && !flush_i && !freeze_i && !rdZero;

  // Lowest invalid slot: isolate the lowest zero bit of slotValid.
  assign grant = ~slotValid & (slotValid + NUM_ENTRIES'(1));

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : gSlot
      sb_slot #(
        .REG_AW  (REG_AW),
        .LOAD_LAT(LOAD_LAT)
      ) uSlot (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .freeze_i (freeze_i),
        .alloc_i  (allocEn & grant[gi]),
        .allocRd_i(RD_i),
        .rs1_i    (RS1_i),
        .rs2_i    (RS2_i),
        .valid_o  (slotValid[gi]),
        .hit1_o   (hit1[gi]),
        .hit2_o   (hit2[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stallCountReg <= '0;
    end else if (hz && !freeze_i && (stallCountReg != {PERF_W{1'b1}})) begin
      stallCountReg <= stallCountReg + 1'b1;
    end
  end

  assign stallCount_o = stallCountReg;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard across four parameterisations:
//   u0 defaults (LOAD_LAT=1), u1 LOAD_LAT=3, u2 NUM_ENTRIES=2/LOAD_LAT=4,
//   u3 LOAD_LAT=12/PERF_W=3 for counter saturation.
module tb_load_use_scoreboard;

  typedef struct packed {
    logic       memRead;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1Used;
    logic       rs2Used;
    logic       flush;
    logic       freeze;
  } in_t;

  typedef struct {
    int    dut;
    logic  hz;
    logic  full;
    int    cnt;
    string tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  in_t         din [4];
  logic        noOp [4];
  logic        stall [4];
  logic        pcw [4];
  logic        full [4];
  logic [31:0] cnt0, cnt1, cnt2;
  logic [2:0]  cnt3;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_use_scoreboard u0 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(din[0].memRead), .RD_i(din[0].rd),
    .RS1_i(din[0].rs1), .RS2_i(din[0].rs2), .RS1Used_i(din[0].rs1Used), .RS2Used_i(din[0].rs2Used),
    .flush_i(din[0].flush), .freeze_i(din[0].freeze), .noOpSignal_o(noOp[0]), .stallSignal_o(stall[0]),
    .PCWriteSignal_o(pcw[0]), .full_o(full[0]), .stallCount_o(cnt0));

  load_use_scoreboard #(.LOAD_LAT(3)) u1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(din[1].memRead), .RD_i(din[1].rd),
    .RS1_i(din[1].rs1), .RS2_i(din[1].rs2), .RS1Used_i(din[1].rs1Used), .RS2Used_i(din[1].rs2Used),
    .flush_i(din[1].flush), .freeze_i(din[1].freeze), .noOpSignal_o(noOp[1]), .stallSignal_o(stall[1]),
    .PCWriteSignal_o(pcw[1]), .full_o(full[1]), .stallCount_o(cnt1));

  load_use_scoreboard #(.NUM_ENTRIES(2), .LOAD_LAT(4)) u2 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(din[2].memRead), .RD_i(din[2].rd),
    .RS1_i(din[2].rs1), .RS2_i(din[2].rs2), .RS1Used_i(din[2].rs1Used), .RS2Used_i(din[2].rs2Used),
    .flush_i(din[2].flush), .freeze_i(din[2].freeze), .noOpSignal_o(noOp[2]), .stallSignal_o(stall[2]),
    .PCWriteSignal_o(pcw[2]), .full_o(full[2]), .stallCount_o(cnt2));

  load_use_scoreboard #(.LOAD_LAT(12), .PERF_W(3)) u3 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(din[3].memRead), .RD_i(din[3].rd),
    .RS1_i(din[3].rs1), .RS2_i(din[3].rs2), .RS1Used_i(din[3].rs1Used), .RS2Used_i(din[3].rs2Used),
    .flush_i(din[3].flush), .freeze_i(din[3].freeze), .noOpSignal_o(noOp[3]), .stallSignal_o(stall[3]),
    .PCWriteSignal_o(pcw[3]), .full_o(full[3]), .stallCount_o(cnt3));

  function automatic in_t mk(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic u1, input logic u2,
                             input logic fl, input logic fz);
    in_t v;
    v.memRead = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.rs1Used = u1; v.rs2Used = u2; v.flush = fl; v.freeze = fz;
    return v;
  endfunction

  function automatic in_t ld(input logic [4:0] rd, input logic [4:0] rs1);
    return mk(1'b1, rd, rs1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic in_t use2(input logic [4:0] rs1, input logic [4:0] rs2);
    return mk(1'b0, 5'd0, rs1, rs2, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one ID instruction on the falling edge, queue its expected outputs,
  // then pop and compare 1 ns later, well before the next rising edge.
  task automatic step(input int d, input in_t v, input logic eHz, input logic eFull,
                      input int eCnt, input string tag);
    exp_t e;
    logic [31:0] obsCnt;
    @(negedge clk);
    din[d] = v;
    sbq.push_back('{d, eHz, eFull, eCnt, tag});
    #1;
    e = sbq.pop_front();
    case (e.dut)
      0:       obsCnt = cnt0;
      1:       obsCnt = cnt1;
      2:       obsCnt = cnt2;
      default: obsCnt = {29'd0, cnt3};
    endcase
    chk($sformatf("%s noOp", e.tag), {31'd0, noOp[e.dut]}, {31'd0, e.hz});
    chk($sformatf("%s stall", e.tag), {31'd0, stall[e.dut]}, {31'd0, e.hz});
    chk($sformatf("%s PCWrite", e.tag), {31'd0, pcw[e.dut]}, {31'd0, !e.hz});
    chk($sformatf("%s full", e.tag), {31'd0, full[e.dut]}, {31'd0, e.full});
    chk($sformatf("%s stallCount", e.tag), obsCnt, e.cnt);
    $display("step %-14s dut=%0d hz=%0b full=%0b count=%0d", e.tag, e.dut, stall[e.dut], full[e.dut], obsCnt);
  endtask

  initial begin
    in_t idle;
    idle = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset / idle
    step(0, idle, 1'b0, 1'b0, 0, "rst_u0");
    step(1, idle, 1'b0, 1'b0, 0, "rst_u1");
    step(2, idle, 1'b0, 1'b0, 0, "rst_u2");
    step(3, idle, 1'b0, 1'b0, 0, "rst_u3");

    // LOAD_LAT=1: dependent instruction right behind a load stalls one cycle
    step(0, ld(5'd5, 5'd1),     1'b0, 1'b0, 0, "lat1_load");
    step(0, use2(5'd5, 5'd1),   1'b1, 1'b0, 0, "lat1_stall");
    step(0, use2(5'd5, 5'd1),   1'b0, 1'b0, 1, "lat1_go");
    step(0, idle,               1'b0, 1'b0, 1, "lat1_idle");

    // Freeze while x5 pending with cnt=1
    step(0, ld(5'd5, 5'd1),     1'b0, 1'b0, 1, "frz_load");
    for (int i = 0; i < 3; i++)
      step(0, mk(1'b0, 5'd0, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1), 1'b1, 1'b0, 1, $sformatf("frz_%0d", i));
    step(0, use2(5'd5, 5'd1),   1'b1, 1'b0, 1, "frz_release");
    step(0, use2(5'd5, 5'd1),   1'b0, 1'b0, 2, "frz_go");

    // Flushed load does not allocate; flushed consumer still sees the hazard
    step(0, mk(1'b1, 5'd9, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0, 1'b0, 2, "flush_load");
    step(0, use2(5'd9, 5'd2),   1'b0, 1'b0, 2, "flush_use9");
    step(0, ld(5'd5, 5'd1),     1'b0, 1'b0, 2, "flush_ld5");
    step(0, mk(1'b0, 5'd0, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, 1'b0, 2, "flush_hz");
    step(0, idle,               1'b0, 1'b0, 3, "flush_idle");

    // No self-hazard; unused operand ignored; rs2 match
    step(0, ld(5'd4, 5'd4),     1'b0, 1'b0, 3, "self_load");
    step(0, idle,               1'b0, 1'b0, 3, "self_idle");
    step(0, ld(5'd7, 5'd1),     1'b0, 1'b0, 3, "unused_load");
    step(0, mk(1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 3, "unused_rs1");
    step(0, ld(5'd8, 5'd1),     1'b0, 1'b0, 3, "rs2_load");
    step(0, use2(5'd1, 5'd8),   1'b1, 1'b0, 3, "rs2_stall");
    step(0, idle,               1'b0, 1'b0, 4, "rs2_idle");

    // LOAD_LAT=3: one independent instruction in between -> 2 stalls
    step(1, ld(5'd7, 5'd1),     1'b0, 1'b0, 0, "lat3_load");
    step(1, idle,               1'b0, 1'b0, 0, "lat3_nop");
    step(1, use2(5'd7, 5'd0),   1'b1, 1'b0, 0, "lat3_st1");
    step(1, use2(5'd7, 5'd0),   1'b1, 1'b0, 1, "lat3_st2");
    step(1, use2(5'd7, 5'd0),   1'b0, 1'b0, 2, "lat3_go");
    // Loads to x0 never allocate: four of them would otherwise fill the table
    for (int i = 0; i < 4; i++)
      step(1, ld(5'd0, 5'd1),   1'b0, 1'b0, 2, $sformatf("x0_load%0d", i));
    step(1, idle,               1'b0, 1'b0, 2, "x0_notfull");
    step(1, use2(5'd0, 5'd0),   1'b0, 1'b0, 2, "x0_use");
    // Duplicate rd: hazard lasts until the younger slot drains
    step(1, ld(5'd7, 5'd1),     1'b0, 1'b0, 2, "dup_load1");
    step(1, ld(5'd7, 5'd1),     1'b0, 1'b0, 2, "dup_load2");
    step(1, use2(5'd7, 5'd0),   1'b1, 1'b0, 2, "dup_st1");
    step(1, use2(5'd7, 5'd0),   1'b1, 1'b0, 3, "dup_st2");
    step(1, use2(5'd7, 5'd0),   1'b1, 1'b0, 4, "dup_st3");
    step(1, use2(5'd7, 5'd0),   1'b0, 1'b0, 5, "dup_go");
    step(1, idle,               1'b0, 1'b0, 5, "dup_idle");

    // Full table: NUM_ENTRIES=2, LOAD_LAT=4
    step(2, ld(5'd1, 5'd10),    1'b0, 1'b0, 0, "full_ld1");
    step(2, ld(5'd2, 5'd10),    1'b0, 1'b0, 0, "full_ld2");
    step(2, ld(5'd3, 5'd10),    1'b1, 1'b1, 0, "full_st1");
    step(2, ld(5'd3, 5'd10),    1'b1, 1'b1, 1, "full_st2");
    step(2, ld(5'd3, 5'd10),    1'b1, 1'b1, 2, "full_st3");
    step(2, ld(5'd3, 5'd10),    1'b0, 1'b0, 3, "full_alloc");
    step(2, use2(5'd3, 5'd10),  1'b1, 1'b0, 3, "full_use3");
    step(2, idle,               1'b0, 1'b0, 4, "full_idle");

    // Saturation: PERF_W=3
    step(3, ld(5'd3, 5'd1),     1'b0, 1'b0, 0, "sat_load");
    for (int k = 0; k < 10; k++)
      step(3, use2(5'd3, 5'd1), 1'b1, 1'b0, (k > 7) ? 7 : k, $sformatf("sat_%0d", k));
    step(3, idle,               1'b0, 1'b0, 7, "sat_idle");

    // Reset mid-operation drops pending slots and clears the counter
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(2, use2(5'd3, 5'd10),  1'b0, 1'b0, 0, "midrst_u2");
    step(3, use2(5'd3, 5'd1),   1'b0, 1'b0, 0, "midrst_u3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
